// File: rtl/player_feedback_if.sv
// Signal bundle between the controller side (buzz-in result, CPU verdict)
// and the player feedback block that drives the LEDs and buzzer.
interface player_feedback_if;
    logic       playerInputFlag;
    logic [1:0] firstPlayerFlag;
    logic       resultValid;
    logic       resultCorrect;
    logic       clearLock;
    logic [3:0] playerLed;
    logic       buzzer;
    logic       busy;

    // Controller side: supplies arbitration/verdict, observes the outputs.
    modport master (
        output playerInputFlag, firstPlayerFlag, resultValid, resultCorrect, clearLock,
        input  playerLed, buzzer, busy
    );

    // Feedback block side.
    modport slave (
        input  playerInputFlag, firstPlayerFlag, resultValid, resultCorrect, clearLock,
        output playerLed, buzzer, busy
    );
endinterface

// File: rtl/player_feedback.sv
// Player feedback: locks onto the first player to buzz, lights that player's
// LED, plays a blink (correct) or buzz (wrong) pattern when the CPU posts a
// verdict, then waits for every button to be released before re-arming.
// Outputs are registered from the current state, so they trail the state
// register by one clock.
module player_feedback #(
    parameter int unsigned TICK   = 12500000,
    parameter int unsigned BLINKS = 3
) (
    input  logic              clk,
    input  logic              rst,
    player_feedback_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOCK    = 2'd1,
        SHOW    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic [27:0] TICK_LAST  = 28'(TICK - 1);
    localparam logic [7:0]  PHASE_LAST = 8'(2 * BLINKS - 1);

    state_t      state, state_d;
    logic [1:0]  owner, owner_d;
    logic        verdict, verdict_d;
    logic [27:0] tick_cnt, tick_cnt_d;
    logic [7:0]  phase_cnt, phase_cnt_d;

    logic [3:0]  led_d;
    logic        buzzer_d;
    logic        busy_d;
    logic        phase_on;
    logic [3:0]  owner_onehot;

    // State register and round context (owner, verdict, blink counters).
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state     <= IDLE;
            owner     <= 2'd0;
            verdict   <= 1'b0;
            tick_cnt  <= 28'd0;
            phase_cnt <= 8'd0;
        end else begin
            state     <= state_d;
            owner     <= owner_d;
            verdict   <= verdict_d;
            tick_cnt  <= tick_cnt_d;
            phase_cnt <= phase_cnt_d;
        end
    end

    // Next-state and context update; clearLock beats resultValid in LOCK.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d     = state;
        owner_d     = owner;
        verdict_d   = verdict;
        tick_cnt_d  = tick_cnt;
        phase_cnt_d = phase_cnt;
        unique case (state)
            IDLE: begin
                if (bus.playerInputFlag) begin
                    owner_d = bus.firstPlayerFlag;
                    state_d = LOCK;
                end
            end
            LOCK: begin
                if (bus.clearLock) begin
                    state_d = RELEASE;
                end else if (bus.resultValid) begin
                    verdict_d   = bus.resultCorrect;
                    tick_cnt_d  = 28'd0;
                    phase_cnt_d = 8'd0;
                    state_d     = SHOW;
                end
            end
            SHOW: begin
                if (bus.clearLock) begin
                    state_d = RELEASE;
                end else if (tick_cnt == TICK_LAST) begin
                    tick_cnt_d = 28'd0;
                    if (phase_cnt == PHASE_LAST) begin
                        state_d = RELEASE;
                    end else begin
                        phase_cnt_d = phase_cnt + 8'd1;
                    end
                end else begin
                    tick_cnt_d = tick_cnt + 28'd1;
                end
            end
            RELEASE: begin
                // A held button must not re-lock; wait for a clean release.
                if (!bus.playerInputFlag) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign phase_on     = ~phase_cnt[0];
    assign owner_onehot = 4'b0001 << owner;

    // Output decode from the current state and counters.
    always_comb begin
        led_d    = 4'b0000;
        buzzer_d = 1'b0;
        busy_d   = (state != IDLE);
        unique case (state)
            LOCK: led_d = owner_onehot;
            SHOW: begin
                if (verdict) begin
                    led_d = phase_on ? owner_onehot : 4'b0000;
                end else begin
                    led_d    = owner_onehot;
                    buzzer_d = phase_on;
                end
            end
            default: ;
        endcase
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.playerLed <= 4'b0000;
            bus.buzzer    <= 1'b0;
            bus.busy      <= 1'b0;
        end else begin
            bus.playerLed <= led_d;
            bus.buzzer    <= buzzer_d;
            bus.busy      <= busy_d;
        end
    end

endmodule

// File: tb/tb_player_feedback.sv
// Directed bench for player_feedback with TICK=4, BLINKS=2.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_player_feedback;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    player_feedback_if bus ();

    player_feedback #(.TICK(4), .BLINKS(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [3:0] led, input logic bz, input logic by);
        check({tag, ".led"},    bus.playerLed,        led);
        check({tag, ".buzzer"}, {3'b000, bus.buzzer}, {3'b000, bz});
        check({tag, ".busy"},   {3'b000, bus.busy},   {3'b000, by});
    endtask

    initial begin
        bus.playerInputFlag = 1'b1;
        bus.firstPlayerFlag = 2'd2;
        bus.resultValid     = 1'b0;
        bus.resultCorrect   = 1'b0;
        bus.clearLock       = 1'b0;

        // 1. Reset held two cycles with a button pressed.
        step();
        check_out("rst0", 4'b0000, 1'b0, 1'b0);
        step();
        check_out("rst1", 4'b0000, 1'b0, 1'b0);
        rst = 1'b0;

        // 2. Lock on p3; later firstPlayerFlag changes are ignored.
        step();
        check_out("lock_entry", 4'b0000, 1'b0, 1'b0);
        bus.firstPlayerFlag = 2'd1;
        step();
        check_out("lock_on", 4'b0100, 1'b0, 1'b1);
        step();
        check_out("lock_frozen", 4'b0100, 1'b0, 1'b1);

        // 3. Correct verdict: blink pattern, then RELEASE, then IDLE.
        bus.resultValid     = 1'b1;
        bus.resultCorrect   = 1'b1;
        bus.playerInputFlag = 1'b0;
        step();
        bus.resultValid = 1'b0;
        check_out("ok_accept", 4'b0100, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            step();
            check_out($sformatf("ok_pat%0d", i), ((i / 4) % 2 == 0) ? 4'b0100 : 4'b0000, 1'b0, 1'b1);
        end
        step();
        check_out("ok_release", 4'b0000, 1'b0, 1'b1);
        step();
        check_out("ok_idle", 4'b0000, 1'b0, 1'b0);

        // 4. Wrong verdict: steady LED, buzzer pattern.
        bus.playerInputFlag = 1'b1;
        bus.firstPlayerFlag = 2'd2;
        step();
        bus.playerInputFlag = 1'b0;
        step();
        check_out("bad_lock", 4'b0100, 1'b0, 1'b1);
        bus.resultValid   = 1'b1;
        bus.resultCorrect = 1'b0;
        step();
        bus.resultValid = 1'b0;
        check_out("bad_accept", 4'b0100, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            step();
            check_out($sformatf("bad_pat%0d", i), 4'b0100, ((i / 4) % 2 == 0), 1'b1);
        end
        step();
        check_out("bad_release", 4'b0000, 1'b0, 1'b1);
        step();
        check_out("bad_idle", 4'b0000, 1'b0, 1'b0);

        // 5. clearLock and resultValid together: clearLock wins.
        bus.playerInputFlag = 1'b1;
        bus.firstPlayerFlag = 2'd2;
        step();
        step();
        check_out("sim_lock", 4'b0100, 1'b0, 1'b1);
        bus.clearLock     = 1'b1;
        bus.resultValid   = 1'b1;
        bus.resultCorrect = 1'b1;
        step();
        bus.clearLock   = 1'b0;
        bus.resultValid = 1'b0;
        check_out("sim_edge", 4'b0100, 1'b0, 1'b1);
        step();
        check_out("sim_rel0", 4'b0000, 1'b0, 1'b1);
        step();
        check_out("sim_rel1", 4'b0000, 1'b0, 1'b1);
        bus.playerInputFlag = 1'b0;
        step();
        check_out("sim_rel2", 4'b0000, 1'b0, 1'b1);
        step();
        check_out("sim_idle", 4'b0000, 1'b0, 1'b0);

        // 6. Reset during the second half-period of SHOW, then buzz on p4.
        bus.playerInputFlag = 1'b1;
        step();
        bus.playerInputFlag = 1'b0;
        step();
        bus.resultValid   = 1'b1;
        bus.resultCorrect = 1'b1;
        step();
        bus.resultValid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
        end
        check_out("mid_show_off", 4'b0000, 1'b0, 1'b1);
        rst = 1'b1;
        step();
        check_out("mid_rst", 4'b0000, 1'b0, 1'b0);
        rst = 1'b0;
        step();
        check_out("post_rst_idle", 4'b0000, 1'b0, 1'b0);
        bus.playerInputFlag = 1'b1;
        bus.firstPlayerFlag = 2'd3;
        step();
        bus.playerInputFlag = 1'b0;
        step();
        check_out("p4_lock", 4'b1000, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/player_feedback.md
# player_feedback

Output-side counterpart to the player input front end: drives each player station's indicator LED and the shared buzzer from the buzz-in arbitration result and the CPU's answer verdict. It locks onto the first player to buzz, holds that player's LED on, plays a correct or wrong pattern when the CPU posts a result, then waits for all buttons to be released before re-arming. Sits between the controller input block (`playerInputFlag`, `firstPlayerFlag`) and the GPIO output pins.

## Interface
Parameters:
- `TICK`, default 12500000: cycles per blink half-period (250 ms at 50 MHz). Range 1 to 2^28−1.
- `BLINKS`, default 3: full on/off blink cycles per result pattern. Range 1 to 127.

Ports:
- `clk`  in  1  system clock (50 MHz).
- `rst`  in  1  reset. One clock; reset is synchronous and active-high.
- `playerInputFlag`  in  1  level; a player's button is currently asserted.
- `firstPlayerFlag`  in  2  registered winning player index; 0 = p1 … 3 = p4.
- `resultValid`  in  1  one-cycle pulse from the CPU; the verdict is on `resultCorrect`.
- `resultCorrect`  in  1  1 = correct answer, 0 = wrong; sampled only with `resultValid`.
- `clearLock`  in  1  one-cycle pulse; the CPU abandons the round.
- `playerLed`  out  4  per-station LED; bit0 = p1, bit3 = p4. Registered.
- `buzzer`  out  1  shared buzzer drive. Registered.
- `busy`  out  1  1 in every state except IDLE. Registered.

## Operation
States: IDLE, LOCK, SHOW, RELEASE.

- **Reset.** State is IDLE; `playerLed`=0000, `buzzer`=0, `busy`=0. Both counters are cleared, and the owner and verdict registers are cleared to 0.
- **IDLE.**
  - All outputs are 0.
  - If `playerInputFlag`=1: capture `firstPlayerFlag` into `owner` and go to LOCK.
  - `resultValid` and `clearLock` are ignored.
- **LOCK.**
  - `playerLed` is one-hot on `owner`; `buzzer`=0.
  - `owner` is frozen; later changes on `firstPlayerFlag` or `playerInputFlag` are ignored.
  - If `clearLock`=1: go to RELEASE. `clearLock` has priority over a simultaneous `resultValid`.
  - Else if `resultValid`=1: capture `resultCorrect` into `verdict`, clear `tickCnt` and `phaseCnt`, and go to SHOW.
- **SHOW.** Runs 2·BLINKS half-periods of TICK cycles each. The phase is on when `phaseCnt` is even.
  - `verdict`=1: `playerLed[owner]` = phase; all other LEDs 0; `buzzer`=0.
  - `verdict`=0: `playerLed[owner]` is on steadily; `buzzer` = phase.
  - `tickCnt` counts 0 to TICK−1. At TICK−1 it wraps to 0 and `phaseCnt` increments.
  - When `tickCnt`=TICK−1 and `phaseCnt`=2·BLINKS−1: go to RELEASE.
  - `clearLock`=1: go to RELEASE immediately. `resultValid` is ignored.
- **RELEASE.**
  - All outputs are 0 and `busy`=1.
  - Stays in RELEASE while `playerInputFlag`=1. The first sampled 0 moves to IDLE.
  - This prevents a held button from re-locking.
- **Counter widths.** `tickCnt` is 28 bits and `phaseCnt` is 8 bits. Neither counter ever exceeds its terminal value.

## Timing
- **Output latency.** All outputs are registered and reflect the state entered at the preceding edge. Input sampled at edge N gives its output effect after edge N+1.
- **Lock.** `playerInputFlag` sampled high at edge N gives `playerLed[owner]`=1 and `busy`=1 visible after edge N+1.
- **SHOW duration.** The first on-phase begins the cycle after `resultValid` is sampled. SHOW lasts exactly 2·BLINKS·TICK cycles, followed by a minimum of one RELEASE cycle before IDLE.
- **Pulse inputs.** `resultValid` and `clearLock` are single-cycle pulses. If held longer, they act only in the states listed above.
- **Reset priority.** `rst` overrides everything in any state. Outputs read reset values after the same edge.

## Test plan
Run with TICK=4 and BLINKS=2.
1. **Reset.** Hold `rst`=1 for 2 cycles with `playerInputFlag`=1 → `playerLed`=0000, `buzzer`=0, `busy`=0; LOCK is not entered until `rst` falls.
2. **Lock.** `playerInputFlag`=1, `firstPlayerFlag`=2 → next cycle `playerLed`=0100 and `busy`=1. Then change `firstPlayerFlag` to 1 → `playerLed` stays 0100.
3. **Correct verdict.** From the LOCK state of test 2, pulse `resultValid` with `resultCorrect`=1 → `playerLed` reads 0100×4, 0000×4, 0100×4, 0000×4 cycles. Then, with `playerInputFlag`=0, one RELEASE cycle with `busy`=1, then IDLE with `busy`=0.
4. **Wrong verdict.** With `resultCorrect`=0 → `playerLed`=0100 for 16 cycles; `buzzer` reads 1×4, 0×4, 1×4, 0×4.
5. **Simultaneous pulses.** In LOCK, pulse `clearLock` and `resultValid` on the same cycle with `playerInputFlag` held at 1 → no pattern, `playerLed`=0000, `busy` stays 1. Drop `playerInputFlag` → IDLE on the next cycle.
6. **Reset mid-SHOW.** Assert `rst` during the 2nd half-period of SHOW → after the edge all outputs are 0 and state is IDLE. A subsequent buzz on p4 gives `playerLed`=1000.
